// File: rtl/alu_vector_writer.sv
// Sweeps every 74181 {s,M,ci,a,b} combination and streams {s,M,ci,a,b,y} words; SETTLE+2 cycles per word.
// A low vec_ready stalls in EMIT with alu_* and vec_data frozen until the handshake.
module alu_vector_writer #(
    parameter int SETTLE     = 1,
    parameter int LAST_INDEX = 16383
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  alu_s,
    output logic        alu_m,
    output logic        alu_ci,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    input  logic [3:0]  alu_y,
    output logic [17:0] vec_data,
    output logic        vec_valid,
    input  logic        vec_ready,
    output logic        busy,
    output logic        done,
    output logic [14:0] vec_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic [13:0] LAST       = 14'(LAST_INDEX);
    localparam logic [3:0]  SETTLE_END = 4'(SETTLE - 1);

    state_t      state;
    state_t      state_nxt;
    logic [13:0] idx;
    logic [13:0] idx_inc;
    logic [3:0]  settle_cnt;
    logic        accept;
    logic        at_last;

    assign accept  = (state == ST_EMIT) && vec_valid && vec_ready;
    assign at_last = (idx == LAST);
    assign idx_inc = idx + 14'd1;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_DRIVE;
            ST_DRIVE:   if (settle_cnt == SETTLE_END) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_EMIT;
            ST_EMIT:    if (accept) state_nxt = at_last ? ST_DONE : ST_DRIVE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= 14'd0;
            settle_cnt <= 4'd0;
            alu_s      <= 4'd0;
            alu_m      <= 1'b0;
            alu_ci     <= 1'b0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            vec_data   <= 18'd0;
            vec_valid  <= 1'b0;
            vec_count  <= 15'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx        <= 14'd0;
                        settle_cnt <= 4'd0;
                        vec_count  <= 15'd0;
                        {alu_s, alu_m, alu_ci, alu_a, alu_b} <= 14'd0;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                ST_CAPTURE: begin
                    vec_data  <= {idx, alu_y};
                    vec_valid <= 1'b1;
                end
                ST_EMIT: begin
                    if (accept) begin
                        vec_valid <= 1'b0;
                        vec_count <= vec_count + 15'd1;
                        // The final index is never incremented, so idx cannot wrap past LAST.
                        if (!at_last) begin
                            idx        <= idx_inc;
                            settle_cnt <= 4'd0;
                            {alu_s, alu_m, alu_ci, alu_a, alu_b} <= idx_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
